// File: rtl/cam_pwr_seq.sv
// Camera power-up/reset sequencer: times PWDN, RESET and boot wait off a prescaled
// microsecond tick, hands off to the SCCB loader and reports READY or FAULT.
module cam_pwr_seq #(
    parameter int CLK_DIV   = 50,
    parameter int T_PWDN_US = 1000,
    parameter int T_RST_US  = 1000,
    parameter int T_BOOT_US = 2000,
    parameter int CFG_TO_US = 50000,
    parameter int CNT_W     = 20
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    input  logic       cfg_done,
    output logic       cam_pwdn,
    output logic       cam_rst_n,
    output logic       xclk_en,
    output logic       cfg_start,
    output logic       ready,
    output logic       fault,
    output logic       busy,
    output logic [2:0] state
);

    localparam int PRE_W = $clog2(CLK_DIV);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PWDN  = 3'd1,
        S_RST   = 3'd2,
        S_BOOT  = 3'd3,
        S_CFG   = 3'd4,
        S_READY = 3'd5,
        S_FAULT = 3'd6
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [PRE_W-1:0]   r_pre;
    logic [CNT_W-1:0]   r_us;

    logic r_pwdn, r_rst_n, r_xclk, r_cfg_start, r_ready, r_fault, r_busy;
    logic w_pwdn, w_rst_n, w_xclk, w_cfg_start, w_ready, w_fault, w_busy;

    logic w_tick, w_pwdn_done, w_rst_done, w_boot_done, w_cfg_to;

    assign w_tick      = (r_pre == PRE_W'(CLK_DIV - 1));
    assign w_pwdn_done = w_tick && (r_us == CNT_W'(T_PWDN_US - 1));
    assign w_rst_done  = w_tick && (r_us == CNT_W'(T_RST_US - 1));
    assign w_boot_done = w_tick && (r_us == CNT_W'(T_BOOT_US - 1));
    assign w_cfg_to    = w_tick && (r_us == CNT_W'(CFG_TO_US - 1));

    always_comb begin
        w_next = r_state;
        if (abort) begin
            w_next = S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE:  if (start) w_next = S_PWDN;
                S_PWDN:  if (w_pwdn_done) w_next = S_RST;
                S_RST:   if (w_rst_done) w_next = S_BOOT;
                S_BOOT:  if (w_boot_done) w_next = S_CFG;
                // cfg_done beats a timeout landing on the same cycle
                S_CFG: begin
                    if (cfg_done)      w_next = S_READY;
                    else if (w_cfg_to) w_next = S_FAULT;
                end
                S_READY: if (start) w_next = S_PWDN;
                S_FAULT: if (start) w_next = S_PWDN;
                default: w_next = S_IDLE;
            endcase
        end
    end

    // Outputs are decoded from the next state so they change with the state register.
    always_comb begin
        w_pwdn      = 1'b1;
        w_rst_n     = 1'b0;
        w_xclk      = 1'b0;
        w_cfg_start = 1'b0;
        w_ready     = 1'b0;
        w_fault     = 1'b0;
        w_busy      = 1'b0;
        unique case (w_next)
            S_PWDN: begin
                w_xclk = 1'b1;
                w_busy = 1'b1;
            end
            S_RST: begin
                w_pwdn = 1'b0;
                w_xclk = 1'b1;
                w_busy = 1'b1;
            end
            S_BOOT, S_CFG: begin
                w_pwdn  = 1'b0;
                w_rst_n = 1'b1;
                w_xclk  = 1'b1;
                w_busy  = 1'b1;
            end
            S_READY: begin
                w_pwdn  = 1'b0;
                w_rst_n = 1'b1;
                w_xclk  = 1'b1;
                w_ready = 1'b1;
            end
            S_FAULT: w_fault = 1'b1;
            default: ;
        endcase
        w_cfg_start = (w_next == S_CFG) && (r_state != S_CFG);
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_pre       <= '0;
            r_us        <= '0;
            r_pwdn      <= 1'b1;
            r_rst_n     <= 1'b0;
            r_xclk      <= 1'b0;
            r_cfg_start <= 1'b0;
            r_ready     <= 1'b0;
            r_fault     <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_pwdn      <= w_pwdn;
            r_rst_n     <= w_rst_n;
            r_xclk      <= w_xclk;
            r_cfg_start <= w_cfg_start;
            r_ready     <= w_ready;
            r_fault     <= w_fault;
            r_busy      <= w_busy;
            if (w_next != r_state) begin
                r_pre <= '0;
                r_us  <= '0;
            end else if (w_tick) begin
                r_pre <= '0;
                r_us  <= r_us + 1'b1;
            end else begin
                r_pre <= r_pre + 1'b1;
            end
        end
    end

    assign state     = r_state;
    assign cam_pwdn  = r_pwdn;
    assign cam_rst_n = r_rst_n;
    assign xclk_en   = r_xclk;
    assign cfg_start = r_cfg_start;
    assign ready     = r_ready;
    assign fault     = r_fault;
    assign busy      = r_busy;

endmodule

// File: tb/tb_cam_pwr_seq.sv
// Table-driven bench for cam_pwr_seq with a per-cycle expected-output scoreboard.
module tb_cam_pwr_seq;

    logic       clk_in = 1'b0;
    logic       reset;
    logic       start, abort, cfg_done;
    logic       cam_pwdn, cam_rst_n, xclk_en, cfg_start, ready, fault, busy;
    logic [2:0] state;

    always #5 clk_in = ~clk_in;

    cam_pwr_seq #(
        .CLK_DIV  (4),
        .T_PWDN_US(2),
        .T_RST_US (3),
        .T_BOOT_US(2),
        .CFG_TO_US(5),
        .CNT_W    (20)
    ) dut (
        .clk_in   (clk_in),
        .reset    (reset),
        .start    (start),
        .abort    (abort),
        .cfg_done (cfg_done),
        .cam_pwdn (cam_pwdn),
        .cam_rst_n(cam_rst_n),
        .xclk_en  (xclk_en),
        .cfg_start(cfg_start),
        .ready    (ready),
        .fault    (fault),
        .busy     (busy),
        .state    (state)
    );

    // Expected {state, pwdn, rst_n, xclk_en, cfg_start, ready, fault, busy}
    localparam logic [9:0] E_IDLE  = {3'd0, 7'b100_0000};
    localparam logic [9:0] E_PWDN  = {3'd1, 7'b101_0001};
    localparam logic [9:0] E_RST   = {3'd2, 7'b001_0001};
    localparam logic [9:0] E_BOOT  = {3'd3, 7'b011_0001};
    localparam logic [9:0] E_CFGS  = {3'd4, 7'b011_1001};
    localparam logic [9:0] E_CFG   = {3'd4, 7'b011_0001};
    localparam logic [9:0] E_READY = {3'd5, 7'b011_0100};
    localparam logic [9:0] E_FAULT = {3'd6, 7'b100_0010};

    typedef struct {
        logic        st;
        logic        ab;
        logic        cd;
        int unsigned n;
        logic [9:0]  exp;
        string       name;
    } vec_t;

    vec_t       tbl[$];
    logic [9:0] sb[$];
    int         checks   = 0;
    int         failures = 0;

    function automatic logic [9:0] obs();
        return {state, cam_pwdn, cam_rst_n, xclk_en, cfg_start, ready, fault, busy};
    endfunction

    task automatic check(input string name, input logic [9:0] got, input logic [9:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got state=%0d pins=%b, expected state=%0d pins=%b",
                     name, got[9:7], got[6:0], exp[9:7], exp[6:0]);
        end
    endtask

    function automatic void add(input logic st, input logic ab, input logic cd,
                                input int unsigned n, input logic [9:0] exp, input string name);
        vec_t v;
        v.st = st; v.ab = ab; v.cd = cd; v.n = n; v.exp = exp; v.name = name;
        tbl.push_back(v);
    endfunction

    // start from IDLE/READY/FAULT through PWDN(8), RST(12), BOOT(8) into the first CFG cycle
    function automatic void add_to_cfg(input string nm);
        add(1'b1, 1'b0, 1'b0, 1,  E_PWDN, {nm, "_pwdn_entry"});
        add(1'b0, 1'b0, 1'b0, 7,  E_PWDN, {nm, "_pwdn"});
        add(1'b0, 1'b0, 1'b0, 12, E_RST,  {nm, "_rst"});
        add(1'b0, 1'b0, 1'b0, 8,  E_BOOT, {nm, "_boot"});
        add(1'b0, 1'b0, 1'b0, 1,  E_CFGS, {nm, "_cfg_start"});
    endfunction

    task automatic run_table();
        logic [9:0] got;
        foreach (tbl[i]) begin
            for (int unsigned k = 0; k < tbl[i].n; k++) begin
                @(negedge clk_in);
                start    = tbl[i].st;
                abort    = tbl[i].ab;
                cfg_done = tbl[i].cd;
                sb.push_back(tbl[i].exp);
                @(posedge clk_in);
                #1;
                got = obs();
                check($sformatf("%s[%0d]", tbl[i].name, k), got, sb.pop_front());
            end
        end
        tbl.delete();
        @(negedge clk_in);
        start = 1'b0; abort = 1'b0; cfg_done = 1'b0;
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; abort = 1'b0; cfg_done = 1'b0;
        #12;
        check("reset_values", obs(), E_IDLE);
        @(negedge clk_in);
        reset = 1'b1;

        add(1'b0, 1'b0, 1'b0, 3, E_IDLE, "idle_hold");
        add(1'b0, 1'b0, 1'b1, 1, E_IDLE, "idle_cfgdone_ignored");
        add_to_cfg("seq2");
        add(1'b0, 1'b0, 1'b0, 3, E_CFG,   "seq2_cfg_wait");
        add(1'b0, 1'b0, 1'b1, 1, E_READY, "seq2_ready");
        add(1'b0, 1'b0, 1'b0, 2, E_READY, "seq2_ready_hold");
        add(1'b0, 1'b0, 1'b1, 1, E_READY, "ready_cfgdone_ignored");
        add_to_cfg("seq3");
        add(1'b0, 1'b0, 1'b0, 19, E_CFG,   "seq3_cfg_wait");
        add(1'b0, 1'b0, 1'b0, 1,  E_FAULT, "seq3_timeout");
        add(1'b0, 1'b0, 1'b0, 2,  E_FAULT, "seq3_fault_sticky");
        add_to_cfg("seq4");
        add(1'b0, 1'b0, 1'b0, 19, E_CFG,   "seq4_cfg_wait");
        add(1'b0, 1'b0, 1'b1, 1,  E_READY, "seq4_done_at_timeout");
        add(1'b0, 1'b0, 1'b0, 1,  E_READY, "seq4_ready_hold");
        add(1'b1, 1'b1, 1'b0, 1,  E_IDLE,  "abort_over_start");
        add(1'b1, 1'b0, 1'b0, 1,  E_PWDN,  "seq5_pwdn_entry");
        add(1'b0, 1'b0, 1'b0, 7,  E_PWDN,  "seq5_pwdn");
        add(1'b0, 1'b0, 1'b0, 5,  E_RST,   "seq5_rst");
        add(1'b0, 1'b1, 1'b0, 1,  E_IDLE,  "seq5_abort_in_rst");
        add(1'b0, 1'b0, 1'b0, 2,  E_IDLE,  "seq5_idle");
        add(1'b1, 1'b0, 1'b0, 1,  E_PWDN,  "seq5b_pwdn_entry");
        add(1'b0, 1'b0, 1'b0, 7,  E_PWDN,  "seq5b_pwdn");
        add(1'b0, 1'b0, 1'b0, 12, E_RST,   "seq5b_rst");
        add(1'b0, 1'b0, 1'b0, 1,  E_BOOT,  "seq5b_boot_entry");
        add(1'b1, 1'b0, 1'b1, 4,  E_BOOT,  "seq5b_start_in_boot");
        add(1'b0, 1'b0, 1'b0, 3,  E_BOOT,  "seq5b_boot");
        add(1'b0, 1'b0, 1'b0, 1,  E_CFGS,  "seq5b_boot_not_extended");
        add(1'b0, 1'b0, 1'b0, 2,  E_CFG,   "seq5b_cfg");
        add(1'b0, 1'b1, 1'b1, 1,  E_IDLE,  "abort_over_cfgdone");
        add(1'b1, 1'b0, 1'b0, 1,  E_PWDN,  "seq6_pwdn_entry");
        add(1'b0, 1'b0, 1'b0, 7,  E_PWDN,  "seq6_pwdn");
        add(1'b0, 1'b0, 1'b0, 12, E_RST,   "seq6_rst");
        add(1'b0, 1'b0, 1'b0, 3,  E_BOOT,  "seq6_boot");
        run_table();

        // asynchronous reset in the middle of BOOT, checked before the next edge
        #2;
        reset = 1'b0;
        #1;
        check("async_reset_no_clock", obs(), E_IDLE);
        @(posedge clk_in);
        #1;
        check("reset_held_edge", obs(), E_IDLE);
        @(negedge clk_in);
        reset = 1'b1;

        add(1'b0, 1'b0, 1'b0, 2, E_IDLE, "post_reset_idle");
        add_to_cfg("seq6b");
        add(1'b0, 1'b0, 1'b1, 1, E_READY, "seq6b_ready");
        add(1'b1, 1'b0, 1'b0, 1, E_PWDN,  "restart_pwdn_entry");
        add(1'b0, 1'b0, 1'b0, 7, E_PWDN,  "restart_pwdn");
        add(1'b0, 1'b0, 1'b0, 1, E_RST,   "restart_pwdn_len");
        add(1'b0, 1'b1, 1'b0, 1, E_IDLE,  "final_abort");
        run_table();

        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got time limit expected completion");
        $fatal(1);
    end

endmodule
